// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 burst master: turns a core read/write request (1-16 beats)
// into AR/R or AW/W/B transactions, reporting completion with done/err.
module axi_burst_master #(
    parameter logic [3:0]  MASTER_ID = 4'd0,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [3:0]          req_len,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_strb,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_last,
    output logic                done,
    output logic                err,
    output logic [3:0]          AWID,
    output logic [ADDR_W-1:0]   AWADDR,
    output logic [3:0]          AWLEN,
    output logic [2:0]          AWSIZE,
    output logic [1:0]          AWBURST,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WLAST,
    output logic                WVALID,
    input  logic                WREADY,
    input  logic [3:0]          BID,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY,
    output logic [3:0]          ARID,
    output logic [ADDR_W-1:0]   ARADDR,
    output logic [3:0]          ARLEN,
    output logic [2:0]          ARSIZE,
    output logic [1:0]          ARBURST,
    output logic                ARVALID,
    input  logic                ARREADY,
    input  logic [3:0]          RID,
    input  logic [DATA_W-1:0]   RDATA,
    input  logic [1:0]          RRESP,
    input  logic                RLAST,
    input  logic                RVALID,
    output logic                RREADY
);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B} state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic [3:0]          len_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                acc_err_q;
    logic                done_q;
    logic                err_q;

    logic last_beat;
    logic r_hs;
    logic w_hs;
    logic r_beat_err;
    logic b_err;

    assign last_beat  = (cnt_q == len_q);
    assign r_hs       = (state_q == S_R) && RVALID && rd_ready;
    assign w_hs       = (state_q == S_W) && wr_valid && WREADY;
    assign r_beat_err = (RRESP != 2'b00) || (RID != MASTER_ID) || (RLAST != last_beat);
    assign b_err      = (BRESP != 2'b00) || (BID != MASTER_ID);

    // Holding off req_ready during the done cycle spaces back-to-back requests by one idle cycle.
    assign req_ready = rst && (state_q == S_IDLE) && !done_q;

    assign ARID    = MASTER_ID;
    assign ARADDR  = addr_q;
    assign ARLEN   = len_q;
    assign ARSIZE  = 3'b010;
    assign ARBURST = 2'b01;
    assign ARVALID = (state_q == S_AR);

    assign RREADY   = (state_q == S_R) && rd_ready;
    assign rd_valid = (state_q == S_R) && RVALID;
    assign rd_data  = RDATA;
    assign rd_last  = (state_q == S_R) && last_beat;

    assign AWID    = MASTER_ID;
    assign AWADDR  = addr_q;
    assign AWLEN   = len_q;
    assign AWSIZE  = 3'b010;
    assign AWBURST = 2'b01;
    assign AWVALID = (state_q == S_AW);

    assign WVALID   = (state_q == S_W) && wr_valid;
    assign wr_ready = (state_q == S_W) && WREADY;
    assign WDATA    = wr_data;
    assign WSTRB    = wr_strb;
    assign WLAST    = (state_q == S_W) && last_beat;

    assign BREADY = (state_q == S_B);

    assign done = done_q;
    assign err  = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            addr_q    <= '0;
            acc_err_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_q    <= req_addr;
                        len_q     <= req_len;
                        cnt_q     <= '0;
                        acc_err_q <= 1'b0;
                        state_q   <= req_write ? S_AW : S_AR;
                    end
                end
                S_AR: if (ARREADY) state_q <= S_R;
                S_R: begin
                    if (r_hs) begin
                        if (last_beat) begin
                            cnt_q   <= '0;
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                            err_q   <= acc_err_q || r_beat_err;
                        end else begin
                            cnt_q     <= cnt_q + 4'd1;
                            acc_err_q <= acc_err_q || r_beat_err;
                        end
                    end
                end
                S_AW: if (AWREADY) state_q <= S_W;
                S_W: begin
                    if (w_hs) begin
                        if (last_beat) begin
                            cnt_q   <= '0;
                            state_q <= S_B;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                S_B: begin
                    if (BVALID) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                        err_q   <= b_err || acc_err_q;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
